// File: rtl/ram.sv
// 16x16 synchronous RAM with a shared address, single rw control and a registered read port.
// Define RAM_WRITE_FIRST_EN to make write cycles also drive d_in onto d_out (write-through).
module ram (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic [3:0]  address,
  input  logic        rw,
  output logic [15:0] d_out
);

  logic [15:0] mem_q [16];
  logic [15:0] mem_d [16];
  logic [15:0] d_out_q;
  logic [15:0] d_out_d;

  // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    mem_d   = mem_q;
    d_out_d = d_out_q;
    if (rw) begin
      mem_d[address] = d_in;
`ifdef RAM_WRITE_FIRST_EN
      d_out_d = d_in;
`else
      d_out_d = d_out_q;
`endif
    end else begin
      d_out_d = mem_q[address];
    end
  end

  // NOTE: the array is in the async reset on purpose; the datapath expects a cleared store,
  // which rules out mapping onto a RAM macro. Sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      d_out_q <= '0;
    end else begin
      mem_q   <= mem_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: stimulus queues the expected d_out for each edge it drives,
// a monitor compares after every clock edge or reset assertion.
module tb_ram;

`ifdef RAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic [3:0]  address;
  logic        rw;
  logic [15:0] d_out;

  logic [15:0] exp_q [$];
  string       name_q [$];
  int          n_checks;
  int          n_fails;
  logic [15:0] held;   // expected d_out value as last established by the stimulus

  ram dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .address (address),
    .rw      (rw),
    .d_out   (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: each clock edge (or reset assertion) consumes one queued expectation, if any.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) check(name_q.pop_front(), d_out, exp_q.pop_front());
    end
  end

  task automatic rd(input logic [3:0] a, input logic [15:0] expv, input string nm);
    @(negedge clk);
    rw = 1'b0; address = a; d_in = $urandom();
    held = expv;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input string nm);
    @(negedge clk);
    rw = 1'b1; address = a; d_in = d;
    if (WRITE_FIRST) held = d;
    exp_q.push_back(held);
    name_q.push_back(nm);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    held     = 16'h0000;
    rst = 1'b1; rw = 1'b0; address = 4'd0; d_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd(4'd0,  16'h0000, "rst_rd_0");
    rd(4'd7,  16'h0000, "rst_rd_7");
    rd(4'd15, 16'h0000, "rst_rd_15");

    // Write then immediate read-back
    wr(4'd0, 16'h93BD, "wr_0");
    rd(4'd0, 16'h93BD, "rd_after_wr_0");

    // No cross-word corruption
    wr(4'd3, 16'hFFBD, "wr_3");
    rd(4'd0, 16'h93BD, "rd_0_after_wr_3");
    rd(4'd0, 16'h93BD, "idle_rd_0");
    rd(4'd3, 16'hFFBD, "rd_3");

    // d_out behaviour across a write cycle
    rd(4'd0, 16'h93BD, "rd_0_pre_wr5");
    wr(4'd5, 16'h5A5A, "wr_5_dout");
    rd(4'd5, 16'h5A5A, "rd_5");

    // Fill with distinct values, read back in reverse
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i), $sformatf("fill_wr_%0d", i));
    for (int i = 15; i >= 0; i--) rd(4'(i), 16'h1000 + 16'(i), $sformatf("fill_rd_%0d", i));

    // Asynchronous reset in the middle of the low clock phase, with a write pending
    rd(4'd9, 16'h1009, "rd_9_pre_rst");
    @(negedge clk);
    rw = 1'b1; address = 4'd2; d_in = 16'hDEAD;
    held = 16'h0000;
    exp_q.push_back(16'h0000);
    name_q.push_back("async_rst_dout");
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rw = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, $sformatf("post_rst_rd_%0d", i));

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left unconsumed, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
